// File: rtl/pwm_pkg.sv
// Shared types and constants for the dead-time gate-drive stage.
package pwm_pkg;

    localparam int DT_W_DEF      = 4;
    localparam int SWALLOW_W_DEF = 8;
    localparam int SWALLOW_MAX   = (1 << SWALLOW_W_DEF) - 1;

    // Half-bridge drive states; the two DT states hold both outputs low.
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DT_TO_LS = 3'd1,
        ST_LS       = 3'd2,
        ST_DT_TO_HS = 3'd3,
        ST_HS       = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, cleared to 0 by synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the asynchronous input through two stages.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low-side gate drive with programmable dead time,
// short-pulse swallowing and a sticky fault shutdown.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W      = DT_W_DEF,
    parameter int SWALLOW_W = SWALLOW_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 pwm_in,
    input  logic [DT_W-1:0]      dead_cycles,
    input  logic                 fault_in,
    input  logic                 fault_clr,
    output logic                 hs_out,
    output logic                 ls_out,
    output logic                 fault_latched,
    output logic [SWALLOW_W-1:0] swallow_cnt
);

    localparam logic [SWALLOW_W-1:0] SWALLOW_SAT = '1;

    pwm_state_e           state_q, state_d;
    logic [DT_W-1:0]      cnt_q, cnt_d;
    logic                 pwm_q, pwm_d;
    logic                 hs_out_q, hs_out_d;
    logic                 ls_out_q, ls_out_d;
    logic                 fault_latched_q, fault_latched_d;
    logic [SWALLOW_W-1:0] swallow_cnt_q, swallow_cnt_d;
    logic                 swallow_inc;
    logic                 fault_s;

    sync_2ff u_fault_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (fault_in),
        .q     (fault_s)
    );

    // Next-state logic: forced shutdown first, then the dead-time FSM.
    always_comb begin
        pwm_d       = pwm_in;
        state_d     = state_q;
        cnt_d       = cnt_q;
        swallow_inc = 1'b0;

        // A clear request is only honoured once the synchronized fault is gone.
        if (fault_s) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end else begin
            fault_latched_d = fault_latched_q;
        end

        if (fault_s || !ena || fault_latched_q) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = pwm_q ? ST_DT_TO_HS : ST_DT_TO_LS;
                    cnt_d   = dead_cycles;
                end
                ST_LS: begin
                    if (pwm_q) begin
                        state_d = ST_DT_TO_HS;
                        cnt_d   = dead_cycles;
                    end
                end
                ST_HS: begin
                    if (!pwm_q) begin
                        state_d = ST_DT_TO_LS;
                        cnt_d   = dead_cycles;
                    end
                end
                ST_DT_TO_HS: begin
                    // PWM fell back before the dead time expired: pulse is swallowed.
                    if (!pwm_q) begin
                        state_d     = ST_LS;
                        swallow_inc = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = ST_HS;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DT_TO_LS: begin
                    if (pwm_q) begin
                        state_d     = ST_HS;
                        swallow_inc = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = ST_LS;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        // Saturating count of aborted transitions.
        if (swallow_inc && (swallow_cnt_q != SWALLOW_SAT)) begin
            swallow_cnt_d = swallow_cnt_q + 1'b1;
        end else begin
            swallow_cnt_d = swallow_cnt_q;
        end

        // Outputs are decoded from the next state so they are glitch-free flops.
        hs_out_d = (state_d == ST_HS);
        ls_out_d = (state_d == ST_LS);
    end

    // State, counter, flags and registered gate-drive outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_OFF;
            cnt_q           <= '0;
            pwm_q           <= 1'b0;
            hs_out_q        <= 1'b0;
            ls_out_q        <= 1'b0;
            fault_latched_q <= 1'b0;
            swallow_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pwm_q           <= pwm_d;
            hs_out_q        <= hs_out_d;
            ls_out_q        <= ls_out_d;
            fault_latched_q <= fault_latched_d;
            swallow_cnt_q   <= swallow_cnt_d;
        end
    end

    assign hs_out        = hs_out_q;
    assign ls_out        = ls_out_q;
    assign fault_latched = fault_latched_q;
    assign swallow_cnt   = swallow_cnt_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Self-checking bench for pwm_deadtime_gen: pattern table, corner-case
// sequences and a randomized run against a behavioural model.
module tb_pwm_deadtime_gen;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       pwm_in;
    logic [3:0] dead_cycles;
    logic       fault_in;
    logic       fault_clr;
    logic       hs_out;
    logic       ls_out;
    logic       fault_latched;
    logic [7:0] swallow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_deadtime_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .pwm_in        (pwm_in),
        .dead_cycles   (dead_cycles),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .hs_out        (hs_out),
        .ls_out        (ls_out),
        .fault_latched (fault_latched),
        .swallow_cnt   (swallow_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Drive is described as "which side is wanted" plus "how many more dead
    // cycles must pass before that side may be switched on".
    typedef enum int {M_IDLE, M_WAITING, M_DRIVING} mmode_e;
    mmode_e m_mode   = M_IDLE;
    bit     m_target = 1'b0;
    int     m_wait   = 0;
    bit     m_pq = 0, m_f1 = 0, m_fs = 0, m_lat = 0;
    int     m_sw = 0;

    task automatic model_step();
        bit fs_old, lat_old, pq;
        if (!rst_n) begin
            m_mode = M_IDLE; m_target = 0; m_wait = 0;
            m_pq = 0; m_f1 = 0; m_fs = 0; m_lat = 0; m_sw = 0;
            return;
        end
        fs_old  = m_fs;
        lat_old = m_lat;
        pq      = m_pq;
        if (fs_old)         m_lat = 1;
        else if (fault_clr) m_lat = 0;
        if (fs_old || !ena || lat_old) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_WAITING; m_target = pq; m_wait = int'(dead_cycles);
        end else if (m_mode == M_WAITING) begin
            if (pq != m_target) begin
                m_mode = M_DRIVING; m_target = pq;
                if (m_sw < SWALLOW_MAX) m_sw++;
            end else if (m_wait == 0) begin
                m_mode = M_DRIVING;
            end else begin
                m_wait--;
            end
        end else if (pq != m_target) begin
            m_mode = M_WAITING; m_target = pq; m_wait = int'(dead_cycles);
        end
        m_fs = m_f1;
        m_f1 = fault_in;
        m_pq = pwm_in;
    endtask

    // One clock: DUT and model advance on the same edge, outputs compared 1ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_hs",  int'(hs_out),        int'(m_mode == M_DRIVING && m_target));
        check("model_ls",  int'(ls_out),        int'(m_mode == M_DRIVING && !m_target));
        check("model_lat", int'(fault_latched), int'(m_lat));
        check("model_sw",  int'(swallow_cnt),   m_sw);
        check("never_both", int'(hs_out & ls_out), 0);
    endtask

    // ---------------- pattern table ----------------
    typedef struct {
        int d;
        int high;
        int period;
        int exp_hs;
        int exp_ls;
        int exp_gap;
        int exp_sw_per;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int k;
        bit seen;
        int hs_run, ls_run, gap_run, hs_max, ls_max, gap_max, sw0;
        int plen, fpulse;

        vecs[0] = '{d:2, high:5,  period:10, exp_hs:2, exp_ls:2, exp_gap:3, exp_sw_per:0};
        vecs[1] = '{d:0, high:10, period:20, exp_hs:9, exp_ls:9, exp_gap:1, exp_sw_per:0};
        vecs[2] = '{d:1, high:3,  period:8,  exp_hs:1, exp_ls:3, exp_gap:2, exp_sw_per:0};
        vecs[3] = '{d:3, high:4,  period:12, exp_hs:0, exp_ls:8, exp_gap:4, exp_sw_per:1};
        vecs[4] = '{d:3, high:2,  period:10, exp_hs:0, exp_ls:8, exp_gap:2, exp_sw_per:1};

        rst_n = 0; ena = 0; pwm_in = 0; dead_cycles = 4'd3; fault_in = 0; fault_clr = 0;

        // Reset state
        repeat (3) cycle();
        check("rst_hs", int'(hs_out), 0);
        check("rst_ls", int'(ls_out), 0);
        check("rst_lat", int'(fault_latched), 0);
        check("rst_sw", int'(swallow_cnt), 0);
        $display("reset: hs=%0d ls=%0d lat=%0d sw=%0d", hs_out, ls_out, fault_latched, swallow_cnt);

        // Start-up with D=3: ls rises D+1 cycles after leaving OFF
        rst_n = 1;
        repeat (3) cycle();
        ena = 1;
        k = 0; seen = 0;
        do begin
            cycle(); k++;
            if (hs_out) seen = 1;
        end while (!ls_out && k < 20);
        check("startup_ls_latency", k, 5);
        check("startup_hs_quiet", int'(seen), 0);
        $display("startup: ls_out rose after %0d edges", k);

        // Single short pulse, D=3, width 2
        pwm_in = 1; repeat (2) cycle();
        pwm_in = 0; seen = 0;
        repeat (8) begin cycle(); if (hs_out) seen = 1; end
        check("short_hs_quiet", int'(seen), 0);
        check("short_sw", int'(swallow_cnt), 1);
        check("short_ls_back", int'(ls_out), 1);
        $display("short pulse: swallow_cnt=%0d ls=%0d", swallow_cnt, ls_out);

        // Table of periodic patterns
        for (int v = 0; v < 5; v++) begin
            dead_cycles = 4'(vecs[v].d);
            hs_run = 0; ls_run = 0; gap_run = 0; hs_max = 0; ls_max = 0; gap_max = 0; sw0 = 0;
            for (int p = 0; p < 6; p++) begin
                if (p == 3) sw0 = int'(swallow_cnt);
                for (int c = 0; c < vecs[v].period; c++) begin
                    pwm_in = (c < vecs[v].high);
                    cycle();
                    if (p >= 3) begin
                        if (hs_out) hs_run++;
                        else begin if (hs_run > hs_max) hs_max = hs_run; hs_run = 0; end
                        if (ls_out) ls_run++;
                        else begin if (ls_run > ls_max) ls_max = ls_run; ls_run = 0; end
                        if (!hs_out && !ls_out) gap_run++;
                        else begin if (gap_run > gap_max) gap_max = gap_run; gap_run = 0; end
                    end
                end
            end
            check("tbl_hs_width", hs_max, vecs[v].exp_hs);
            check("tbl_ls_width", ls_max, vecs[v].exp_ls);
            check("tbl_gap", gap_max, vecs[v].exp_gap);
            check("tbl_swallow", int'(swallow_cnt) - sw0, 3 * vecs[v].exp_sw_per);
            $display("vector %0d: D=%0d high=%0d period=%0d -> hs=%0d ls=%0d gap=%0d sw+%0d",
                     v, vecs[v].d, vecs[v].high, vecs[v].period, hs_max, ls_max, gap_max,
                     int'(swallow_cnt) - sw0);
        end

        // 300 short pulses saturate the counter
        dead_cycles = 4'd3;
        for (int i = 0; i < 300; i++) begin
            pwm_in = 1; repeat (2) cycle();
            pwm_in = 0; repeat (4) cycle();
        end
        check("sat_sw", int'(swallow_cnt), SWALLOW_MAX);
        $display("saturation: swallow_cnt=%0d", swallow_cnt);

        // Reset in the middle of HS
        dead_cycles = 4'd2; pwm_in = 1; k = 0;
        do begin cycle(); k++; end while (!hs_out && k < 30);
        check("midrst_reach_hs", int'(hs_out), 1);
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("midrst_hs", int'(hs_out), 0);
            check("midrst_ls", int'(ls_out), 0);
            check("midrst_lat", int'(fault_latched), 0);
            check("midrst_sw", int'(swallow_cnt), 0);
        end
        rst_n = 1;
        $display("mid-HS reset: hs=%0d ls=%0d sw=%0d", hs_out, ls_out, swallow_cnt);

        // Fault while in HS
        k = 0;
        do begin cycle(); k++; end while (!hs_out && k < 30);
        check("fault_reach_hs", int'(hs_out), 1);
        fault_in = 1;
        cycle(); check("fault_m0_hs", int'(hs_out), 1);
        cycle(); check("fault_m1_hs", int'(hs_out), 1);
        cycle(); check("fault_m2_hs", int'(hs_out), 0);
        check("fault_m2_lat", int'(fault_latched), 1);
        fault_clr = 1; cycle(); fault_clr = 0;
        check("fault_clr_ignored", int'(fault_latched), 1);
        fault_in = 0; repeat (4) cycle();
        check("fault_still_lat", int'(fault_latched), 1);
        check("fault_off_hs", int'(hs_out), 0);
        fault_clr = 1; cycle(); fault_clr = 0;
        check("fault_cleared", int'(fault_latched), 0);
        k = 0;
        do begin cycle(); k++; end while (!hs_out && k < 30);
        check("fault_restart_latency", k, 4);
        $display("fault: restart hs after %0d edges from clear", k);

        // Randomized run against the model
        plen = 0; fpulse = 0;
        for (int i = 0; i < 4000; i++) begin
            if (plen == 0) begin pwm_in = ~pwm_in; plen = $urandom_range(1, 12); end
            plen--;
            if (fpulse > 0) fpulse--;
            else if ($urandom_range(0, 299) == 0) fpulse = $urandom_range(1, 6);
            fault_in  = (fpulse > 0);
            fault_clr = ($urandom_range(0, 19) == 0);
            ena       = ($urandom_range(0, 199) != 0);
            rst_n     = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 49) == 0) dead_cycles = 4'($urandom_range(0, 5));
            cycle();
        end
        $display("random: 4000 cycles, swallow_cnt=%0d", swallow_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
